// File: rtl/cpu_mem_pkg.sv
`timescale 1ns/1ps
// Shared types for the CPU memory-port arbiter: FSM states, owner encoding, default widths.
package cpu_mem_pkg;

  localparam int unsigned AW_DEF = 32;
  localparam int unsigned DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_prio.sv
`timescale 1ns/1ps
// Winner select for the memory port: LSU has fixed priority unless IF has been
// passed over STARVE_LIMIT times in a row, tracked by a saturating starvation counter.
module mem_arb_prio
  import cpu_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   if_req_i,
  input  logic   lsu_req_i,
  input  logic   grant_i,
  output owner_e winner_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    winner_o = OWN_LSU;
    if (if_req_i && (!lsu_req_i || starve_cnt_q == LIMIT)) winner_o = OWN_IF;
  end

  // Only an LSU win over a waiting IF counts as starvation; any other grant clears it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_i) begin
      if (winner_o == OWN_LSU && if_req_i)
        starve_cnt_d = (starve_cnt_q == LIMIT) ? LIMIT : starve_cnt_q + 4'd1;
      else
        starve_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) starve_cnt_q <= '0;
    else         starve_cnt_q <= starve_cnt_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Shares the single memory port between instruction fetch and load/store,
// one transaction outstanding at a time (IDLE -> REQ -> RSP).
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned AW           = AW_DEF,
  parameter int unsigned DW           = DW_DEF,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            lsu_req,
  input  logic            lsu_we,
  input  logic [AW-1:0]   lsu_addr,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_be,
  output logic            lsu_gnt,
  output logic            lsu_rvalid,
  output logic [DW-1:0]   lsu_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d, winner;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
  logic [DW/8-1:0]   mem_be_q, mem_be_d;
  logic              grant, rsp_hit;

  assign grant = (state_q == IDLE) && (if_req || lsu_req);

  mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk_i     (clk),
    .rst_ni    (rst),
    .if_req_i  (if_req),
    .lsu_req_i (lsu_req),
    .grant_i   (grant),
    .winner_o  (winner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_LSU;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (if_req || lsu_req) state_d = REQ;
      REQ:     if (mem_gnt)           state_d = RSP;
      RSP:     if (mem_rvalid)        state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // Payload is captured once in IDLE and held until the next grant; IF fetches are full-word reads.
  always_comb begin
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if (grant) begin
      owner_d   = winner;
      mem_req_d = 1'b1;
      if (winner == OWN_LSU) begin
        mem_we_d    = lsu_we;
        mem_addr_d  = lsu_addr;
        mem_wdata_d = lsu_wdata;
        mem_be_d    = lsu_be;
      end else begin
        mem_we_d    = 1'b0;
        mem_addr_d  = if_addr;
        mem_wdata_d = '0;
        mem_be_d    = '1;
      end
    end else if (state_q == REQ && mem_gnt) begin
      mem_req_d = 1'b0;
    end

    rsp_hit    = (state_q == RSP) && mem_rvalid;
    if_gnt     = (state_q == REQ) && mem_gnt && (owner_q == OWN_IF);
    lsu_gnt    = (state_q == REQ) && mem_gnt && (owner_q == OWN_LSU);
    if_rvalid  = rsp_hit && (owner_q == OWN_IF);
    lsu_rvalid = rsp_hit && (owner_q == OWN_LSU);
    if_rdata   = if_rvalid  ? mem_rdata : '0;
    lsu_rdata  = lsu_rvalid ? mem_rdata : '0;
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

  // Protocol violations by the requesters or the memory are not recovered, only flagged.
  a_if_hold:   assert property (@(posedge clk) disable iff (!rst) (if_req && !if_gnt) |=> if_req);
  a_lsu_hold:  assert property (@(posedge clk) disable iff (!rst) (lsu_req && !lsu_gnt) |=> lsu_req);
  a_gnt_req:   assert property (@(posedge clk) disable iff (!rst) mem_gnt |-> (state_q == REQ));
  a_rv_rsp:    assert property (@(posedge clk) disable iff (!rst) mem_rvalid |-> (state_q == RSP));

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_port_arbiter: transaction-level model of the arbiter, bench-side requesters and memory.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        lsu_req, lsu_we, lsu_gnt, lsu_rvalid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_be;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_be(lsu_be),
    .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; } lsu_t;
  typedef struct { bit lsu; logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; int c; } g_t;

  logic [31:0] if_q[$];
  lsu_t        lsu_q[$];
  g_t          glog[$];
  bit          mreq_log[$];

  int nvec = 0, nfail = 0;
  int cyc = 0, wcnt = 0, gnt_wait = -1, rsp_wait = -1;
  int req_cyc = 0, n_if_rv = 0, n_lsu_rv = 0, lsu_act = 0;
  logic [31:0] last_if_rdata;

  // Transaction-level model: idle / waiting for mem_gnt / waiting for mem_rvalid.
  bit          m_busy, m_acc, m_own_lsu;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  int          m_starve;
  bit          s_if_gnt, s_lsu_gnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_own_lsu = 1; m_starve = 0;
    s_if_gnt = 0; s_lsu_gnt = 0;
    if_q.delete(); lsu_q.delete();
  endtask

  task automatic advance();
    if (!m_busy) begin
      if (if_req || lsu_req) begin
        m_own_lsu = lsu_req && !(if_req && m_starve == LIMIT);
        if (m_own_lsu) begin
          m_we = lsu_we; m_addr = lsu_addr; m_wdata = lsu_wdata; m_be = lsu_be;
          m_starve = if_req ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
        end else begin
          m_we = 1'b0; m_addr = if_addr; m_starve = 0;
        end
        m_busy = 1; m_acc = 0; wcnt = 0;
      end
    end else if (!m_acc) begin
      if (mem_gnt) begin m_acc = 1; wcnt = 0; end
      else wcnt++;
    end else begin
      if (mem_rvalid) m_busy = 0;
      else wcnt++;
    end
    if (s_if_gnt && if_q.size() != 0) void'(if_q.pop_front());
    if (s_lsu_gnt && lsu_q.size() != 0) void'(lsu_q.pop_front());
  endtask

  task automatic drive();
    if_req  = (if_q.size() != 0);
    if_addr = if_req ? if_q[0] : $urandom;
    lsu_req = (lsu_q.size() != 0);
    if (lsu_req) begin
      lsu_we = lsu_q[0].we; lsu_addr = lsu_q[0].addr; lsu_wdata = lsu_q[0].wdata; lsu_be = lsu_q[0].be;
    end else begin
      lsu_we = 1'($urandom); lsu_addr = $urandom; lsu_wdata = $urandom; lsu_be = 4'($urandom);
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
    if (m_busy && !m_acc)
      mem_gnt = (gnt_wait < 0) ? ($urandom_range(0, 2) == 0) : (wcnt >= gnt_wait);
    else if (m_busy) begin
      mem_rvalid = (rsp_wait < 0) ? ($urandom_range(0, 2) == 0) : (wcnt >= rsp_wait);
      mem_rdata  = m_addr + 32'd3;
    end
  endtask

  task automatic check();
    bit e_req, e_rsp;
    e_req = m_busy && !m_acc;
    e_rsp = m_busy && m_acc && mem_rvalid;
    chk("mem_req", 64'(mem_req), 64'(e_req));
    chk("if_gnt", 64'(if_gnt), 64'(e_req && mem_gnt && !m_own_lsu));
    chk("lsu_gnt", 64'(lsu_gnt), 64'(e_req && mem_gnt && m_own_lsu));
    chk("if_rvalid", 64'(if_rvalid), 64'(e_rsp && !m_own_lsu));
    chk("lsu_rvalid", 64'(lsu_rvalid), 64'(e_rsp && m_own_lsu));
    chk("if_rdata", 64'(if_rdata), (e_rsp && !m_own_lsu) ? 64'(mem_rdata) : 64'd0);
    if (!(m_own_lsu && m_we))
      chk("lsu_rdata", 64'(lsu_rdata), (e_rsp && m_own_lsu) ? 64'(mem_rdata) : 64'd0);
    if (m_busy) begin
      chk("mem_we", 64'(mem_we), 64'(m_we));
      chk("mem_addr", 64'(mem_addr), 64'(m_addr));
      if (m_own_lsu) begin
        chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        chk("mem_be", 64'(mem_be), 64'(m_be));
      end
    end
    s_if_gnt = if_gnt; s_lsu_gnt = lsu_gnt;
    mreq_log.push_back(mem_req);
    if (mem_req) req_cyc++;
    if (if_gnt || lsu_gnt) glog.push_back('{lsu_gnt, mem_we, mem_addr, mem_wdata, mem_be, cyc});
    if (if_rvalid) begin n_if_rv++; last_if_rdata = if_rdata; end
    if (lsu_rvalid) n_lsu_rv++;
    if (lsu_gnt || lsu_rvalid || lsu_rdata != 0) lsu_act++;
  endtask

  task automatic step();
    @(posedge clk); #1;
    advance();
    drive();
    @(negedge clk);
    check();
    cyc++;
  endtask

  task automatic run_idle(input int maxc);
    int n = 0;
    while ((m_busy || if_q.size() != 0 || lsu_q.size() != 0) && n < maxc) begin
      step();
      n++;
    end
    if (n >= maxc) begin
      nvec++; nfail++;
      $display("FAIL timeout: still busy after %0d cycles", n);
    end
  endtask

  task automatic clear_logs();
    glog.delete(); mreq_log.delete();
    req_cyc = 0; n_if_rv = 0; n_lsu_rv = 0; lsu_act = 0; last_if_rdata = '0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ctl"}, 64'({if_gnt, if_rvalid, lsu_gnt, lsu_rvalid, mem_req, mem_we}), 64'd0);
    chk({tag, "_rdata"}, {if_rdata, lsu_rdata}, 64'd0);
    chk({tag, "_mem"}, {mem_addr, mem_wdata}, 64'd0);
    chk({tag, "_be"}, 64'(mem_be), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    model_reset();
    clear_logs();
    drive();
    repeat (2) @(negedge clk);
    chk_reset_outs("reset");
    rst = 1'b1;

    // IF-only read, gnt after 2 wait cycles
    gnt_wait = 2; rsp_wait = 0;
    clear_logs();
    if_q.push_back(32'h10);
    run_idle(50);
    chk("t1_ngnt", 64'(glog.size()), 64'd1);
    if (glog.size() >= 1) begin
      chk("t1_addr", 64'(glog[0].addr), 64'h10);
      chk("t1_we", 64'(glog[0].we), 64'd0);
      chk("t1_owner", 64'(glog[0].lsu), 64'd0);
    end
    chk("t1_reqcyc", 64'(req_cyc), 64'd3);
    chk("t1_rdata", 64'(last_if_rdata), 64'h13);
    chk("t1_nrv", 64'(n_if_rv), 64'd1);
    chk("t1_lsu_quiet", 64'(lsu_act), 64'd0);

    // Simultaneous IF read and LSU store, zero-wait memory
    gnt_wait = 0; rsp_wait = 0;
    clear_logs();
    if_q.push_back(32'h20);
    lsu_q.push_back('{1'b1, 32'h100, 32'hDEADBEEF, 4'hF});
    run_idle(50);
    chk("t2_ngnt", 64'(glog.size()), 64'd2);
    if (glog.size() >= 2) begin
      chk("t2_first_lsu", 64'(glog[0].lsu), 64'd1);
      chk("t2_first_we", 64'(glog[0].we), 64'd1);
      chk("t2_first_wdata", 64'(glog[0].wdata), 64'hDEADBEEF);
      chk("t2_second_if", 64'(glog[1].lsu), 64'd0);
      chk("t2_second_addr", 64'(glog[1].addr), 64'h20);
      chk("t2_spacing", 64'(glog[1].c - glog[0].c), 64'd3);
    end

    // LSU hogging the port while IF waits
    gnt_wait = -1; rsp_wait = -1;
    clear_logs();
    if_q.push_back(32'h40);
    for (int i = 0; i < 6; i++) lsu_q.push_back('{1'b0, 32'h200 + 32'(i * 4), 32'h0, 4'hF});
    run_idle(400);
    chk("t3_ngnt", 64'(glog.size()), 64'd7);
    if (glog.size() >= 7)
      for (int i = 0; i < 7; i++) chk("t3_order", 64'(glog[i].lsu), (i == 4) ? 64'd0 : 64'd1);

    // Zero-wait back-to-back IF fetches
    gnt_wait = 0; rsp_wait = 0;
    clear_logs();
    for (int i = 0; i < 3; i++) if_q.push_back(32'h80 + 32'(i * 4));
    run_idle(50);
    if (mreq_log.size() >= 8) begin
      bit pat[8] = '{0, 1, 0, 0, 1, 0, 0, 1};
      for (int i = 0; i < 8; i++) chk("t4_mreq", 64'(mreq_log[i]), 64'(pat[i]));
    end else chk("t4_mreq_len", 64'(mreq_log.size()), 64'd8);
    chk("t4_ngnt", 64'(glog.size()), 64'd3);
    if (glog.size() >= 3) chk("t4_period", 64'(glog[2].c - glog[1].c), 64'd3);

    // Reset while an LSU load waits for its response
    gnt_wait = 0; rsp_wait = 5;
    clear_logs();
    lsu_q.push_back('{1'b0, 32'h300, 32'h0, 4'hF});
    for (int n = 0; n < 20 && !(m_busy && m_acc); n++) step();
    chk("t5_in_rsp", 64'(m_busy && m_acc), 64'd1);
    rst = 1'b0;
    #1;
    chk_reset_outs("t5_async");
    model_reset();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    n_lsu_rv = 0;
    repeat (4) step();
    chk("t5_no_lsu_rv", 64'(n_lsu_rv), 64'd0);
    rsp_wait = 1;
    clear_logs();
    if_q.push_back(32'h30);
    run_idle(50);
    chk("t5_if_rdata", 64'(last_if_rdata), 64'h33);
    chk("t5_if_nrv", 64'(n_if_rv), 64'd1);

    // Partial store
    gnt_wait = -1; rsp_wait = -1;
    clear_logs();
    lsu_q.push_back('{1'b1, 32'h104, 32'h0000CAFE, 4'h3});
    run_idle(100);
    if (glog.size() >= 1) begin
      chk("t6_be", 64'(glog[0].be), 64'h3);
      chk("t6_addr", 64'(glog[0].addr), 64'h104);
      chk("t6_we", 64'(glog[0].we), 64'd1);
    end else chk("t6_ngnt", 64'(glog.size()), 64'd1);
    chk("t6_nrv", 64'(n_lsu_rv), 64'd1);

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      if (if_q.size() == 0 && $urandom_range(0, 3) == 0) if_q.push_back($urandom);
      if (lsu_q.size() == 0 && $urandom_range(0, 2) == 0)
        lsu_q.push_back('{1'($urandom), $urandom, $urandom, 4'($urandom)});
      step();
    end
    run_idle(200);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single memory port between the instruction-fetch requester (IF) and the load/store requester (LSU).
- Serialises accesses with one transaction outstanding at a time.
- LSU has fixed priority; a starvation counter guarantees IF forward progress.
- Sits between the cpu core stages and the unified instruction/data memory.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- STARVE_LIMIT, 4, number of consecutive LSU grants while IF is waiting before IF is forced next; range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- if_req  input  1  IF request; held with if_addr until if_gnt.
- if_addr  input  AW  IF word address.
- if_gnt  output  1  IF request accepted by memory (1-cycle pulse).
- if_rvalid  output  1  IF read data valid (1-cycle pulse).
- if_rdata  output  DW  IF read data.
- lsu_req  input  1  LSU request; held with all lsu_* fields until lsu_gnt.
- lsu_we  input  1  1 = store, 0 = load.
- lsu_addr  input  AW  LSU address.
- lsu_wdata  input  DW  store data.
- lsu_be  input  DW/8  store byte enables.
- lsu_gnt  output  1  LSU request accepted (1-cycle pulse).
- lsu_rvalid  output  1  LSU completion; load data valid, or store done.
- lsu_rdata  output  DW  load data.
- mem_req  output  1  memory request.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_be  output  DW/8  memory byte enables.
- mem_gnt  input  1  memory accepts the request this cycle.
- mem_rvalid  input  1  memory response/completion; also returned for writes.
- mem_rdata  input  DW  memory read data.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE, starve_cnt to 0, owner to LSU.
  - All outputs are 0: mem_* registers, if_* and lsu_* gnt/rvalid, rdata.
  - Asserting reset mid-transaction abandons the transaction; there is no replay.
- FSM states:
  - IDLE: sample requests; if any is pending, latch owner and payload into mem_* registers and go to REQ.
  - REQ: mem_req=1 with fields stable; on mem_gnt, pulse owner gnt the same cycle (combinational from mem_gnt and owner), deassert mem_req on the next edge, go to RSP.
  - RSP: wait for mem_rvalid; mem_rvalid is sampled only in RSP, so it arrives at least 1 cycle after mem_gnt. On mem_rvalid, route it to the owner's rvalid and rdata (combinational), then go to IDLE.
- Latency:
  - A request sampled in IDLE at edge N gives mem_req=1 in cycle N+1.
  - Zero-wait memory (gnt in the first REQ cycle, rvalid the next cycle) gives 3 cycles per transaction including IDLE.
  - Back-to-back requests therefore incur one IDLE bubble.
- Arbitration, evaluated in IDLE only:
  - Only one requesting: that requester wins.
  - Both requesting: LSU wins, unless starve_cnt == STARVE_LIMIT, in which case IF wins.
- starve_cnt (4 bits, updated on grant):
  - LSU granted while if_req=1: increment, saturating at STARVE_LIMIT.
  - IF granted: clear to 0.
  - LSU granted while if_req=0: clear to 0.
- Non-owner outputs: gnt and rvalid of the non-owner are always 0; the non-owner's rdata is 0.
- Illegal input conditions, checked by simulation assertions (not handled in RTL):
  - A requester drops req before its gnt.
  - mem_rvalid arrives outside RSP.
  - mem_gnt arrives outside REQ.

Decomposition:
- Package cpu_mem_pkg holds:
  - the state enum (IDLE, REQ, RSP);
  - the owner encoding (OWN_IF=0, OWN_LSU=1);
  - default AW/DW constants.
- One sub-module, mem_arb_prio: combinational winner select plus the starve_cnt register and its update logic.
- The FSM, payload registers and response routing stay in the top module.

Test Plan:
- IF only, read 0x0000_0010, mem_gnt after 2 wait cycles, rvalid rdata=0x0000_0013 -> mem_addr=0x10, mem_we=0; if_gnt pulses with mem_gnt; if_rvalid=1 with if_rdata=0x13; lsu_* outputs stay 0.
- Simultaneous if_req (0x20) and lsu_req store (0x100, data 0xDEADBEEF, be=0xF) -> LSU served first with mem_we=1, mem_wdata=0xDEADBEEF; IF served next, after one IDLE bubble.
- LSU continuously requesting while IF pending, STARVE_LIMIT=4 -> exactly 4 LSU grants, then IF granted, then starve_cnt=0 and LSU resumes.
- Zero-wait memory, IF back-to-back -> mem_req pattern 0,1,0,0,1 per transaction; 3 cycles per access.
- rst=0 asserted during RSP of an LSU load -> all outputs 0 immediately (async); after rst=1, no lsu_rvalid; a new if_req is served normally.
- Store with lsu_be=0x3 to 0x104 -> mem_be=0x3; lsu_rvalid pulses on mem_rvalid; lsu_rdata is ignored by the checker.
